logic_monostable_n: RTL



---
 rtl/logic_monostable_n.sv | 83 ++++++++
 1 files changed

// File: rtl/logic_monostable_n.sv
// logic_monostable_n: multi-channel clock-synchronous one-shot.
// Each channel fires on the rising edge of T = ~nA & B & nR and holds Q high
// for exactly PW clock cycles, counted by a down-counter. RETRIG selects, per
// channel, whether a trigger during a pulse reloads the counter.
module logic_monostable_n #(
  parameter int                  CHANNELS = 2,
  parameter int                  WIDTH    = 16,
  parameter logic [CHANNELS-1:0] RETRIG   = {CHANNELS{1'b0}}
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CHANNELS-1:0]       nA,
  input  logic [CHANNELS-1:0]       B,
  input  logic [CHANNELS-1:0]       nR,
  input  logic [CHANNELS*WIDTH-1:0] PW,
  output logic [CHANNELS-1:0]       Q,
  output logic [CHANNELS-1:0]       nQ,
  output logic [CHANNELS-1:0]       TRIG
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic             t;
    logic             t_prev_reg;
    logic             trig_event;
    logic             accept;
    logic [WIDTH-1:0] pw;
    logic             q_reg;
    logic             q_next;
    logic             trig_reg;
    logic             trig_next;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;

    assign pw         = PW[gi*WIDTH +: WIDTH];
    assign t          = ~nA[gi] & B[gi] & nR[gi];
    assign trig_event = t & ~t_prev_reg;
    // A zero length never starts a pulse; a busy non-retriggerable channel
    // ignores triggers up to and including its terminal-count cycle.
    assign accept     = trig_event & (pw != '0) & (~q_reg | RETRIG[gi]);

    // Next-state: clear beats trigger beats terminal count beats countdown.
    always_comb begin
      q_next    = q_reg;
      cnt_next  = cnt_reg;
      trig_next = 1'b0;
      if (!nR[gi]) begin
        q_next   = 1'b0;
        cnt_next = '0;
      end else if (accept) begin
        q_next    = 1'b1;
        cnt_next  = pw - ONE;
        trig_next = 1'b1;
      end else if (q_reg && (cnt_reg == '0)) begin
        q_next = 1'b0;
      end else if (q_reg) begin
        cnt_next = cnt_reg - ONE;
      end
    end

    // State register; T history resets high so a trigger level held
    // through reset must be released and re-applied before it fires.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        t_prev_reg <= 1'b1;
        q_reg      <= 1'b0;
        cnt_reg    <= '0;
        trig_reg   <= 1'b0;
      end else begin
        t_prev_reg <= t;
        q_reg      <= q_next;
        cnt_reg    <= cnt_next;
        trig_reg   <= trig_next;
      end
    end

    assign Q[gi]    = q_reg;
    assign nQ[gi]   = ~q_reg;
    assign TRIG[gi] = trig_reg;
  end

endmodule
